// File: rtl/fix2float32_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fix2float32_stage                                               |
// | Purpose  : Final stage of the exponential unit. Normalises an unsigned    |
// |            Q3.23 partial result with an iterative shifter, multiplies it   |
// |            by the FP32 scale factor e^b and emits one IEEE-754 single      |
// |            per accepted job.                                               |
// | Ports    : CLK, RST (sync, active-high)                                    |
// |            start         - one-cycle job strobe, accepted only when idle   |
// |            FIXED_IN      - Q3.23 operand (bits 25:23 int, 22:0 fraction)   |
// |            FLOAT32_SCALE - FP32 scale factor                               |
// |            FLOAT32_OUT   - FP32 result, held until the next done           |
// |            done          - one-cycle pulse, FLOAT32_OUT valid with it      |
// |            ready         - FSM is idle                                     |
// |            overrun       - sticky, start seen while busy                   |
// | Options  : ROUND_NEAREST_EN - round-to-nearest-even instead of truncation |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fix2float32_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [25:0] FIXED_IN,
  input  logic [31:0] FLOAT32_SCALE,
  output logic [31:0] FLOAT32_OUT,
  output logic        done,
  output logic        ready,
  output logic        overrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_NORM = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_PACK = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [25:0]       shift_q;
  logic [31:0]       scale_q;
  logic signed [5:0] ef_q;
  logic              zero_q;
  logic              mul_ph_q;
  logic [47:0]       prod_q;
  logic [22:0]       mant_q;
  logic signed [9:0] exp_q;
  logic [31:0]       out_q;
  logic              overrun_q;
`ifdef ROUND_NEAREST_EN
  logic              guard_q;
  logic              sticky_q;
  logic [23:0]       w_inc;
`else
  // Truncation never looks below the kept mantissa bits.
  logic              w_unused_lsbs;
  assign w_unused_lsbs = ^prod_q[22:0];
`endif

  logic              w_zero;
  logic              w_norm_ok;
  logic signed [9:0] w_exp_base;
  logic [22:0]       w_mant_r;
  logic signed [9:0] w_exp_r;
  logic [31:0]       w_pack;

  assign w_zero     = (shift_q == 26'd0);
  assign w_norm_ok  = ~shift_q[25] & ~shift_q[24] & shift_q[23];
  assign w_exp_base = $signed({2'b00, scale_q[30:23]}) + $signed({{4{ef_q[5]}}, ef_q});

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; MUL spends one cycle on the product and one on selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_NORM;
      S_NORM:  if (w_zero || w_norm_ok) state_d = S_MUL;
      S_MUL:   if (mul_ph_q) state_d = S_PACK;
      S_PACK:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready = (state_q == S_IDLE);
    done  = (state_q == S_DONE);
  end

  assign FLOAT32_OUT = out_q;
  assign overrun     = overrun_q;

  // Rounding and special-case packing from the selected mantissa/exponent.
  always_comb begin
    w_mant_r = mant_q;
    w_exp_r  = exp_q;
`ifdef ROUND_NEAREST_EN
    w_inc = {1'b0, mant_q} + 24'd1;
    if (guard_q && (sticky_q || mant_q[0])) begin
      w_mant_r = w_inc[22:0];
      // All-ones mantissa rolls over: 1.111.. rounds up to 2.0.
      if (w_inc[23]) w_exp_r = exp_q + 10'sd1;
    end
`endif
    if (scale_q[30:23] == 8'hFF)
      w_pack = scale_q;
    else if (zero_q || (scale_q[30:23] == 8'h00))
      w_pack = {scale_q[31], 31'd0};
    else if (w_exp_r >= 10'sd255)
      w_pack = {scale_q[31], 8'hFF, 23'd0};
    else if (w_exp_r <= 10'sd0)
      w_pack = {scale_q[31], 31'd0};
    else
      w_pack = {scale_q[31], w_exp_r[7:0], w_mant_r};
  end

  // Datapath
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q     <= 32'd0;
      overrun_q <= 1'b0;
      zero_q    <= 1'b0;
      mul_ph_q  <= 1'b0;
    end else begin
      if (start && (state_q != S_IDLE)) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shift_q  <= FIXED_IN;
            scale_q  <= FLOAT32_SCALE;
            ef_q     <= 6'sd0;
            zero_q   <= 1'b0;
            mul_ph_q <= 1'b0;
          end
        end
        S_NORM: begin
          if (w_zero) begin
            zero_q <= 1'b1;
          end else if (shift_q[25] || shift_q[24]) begin
            shift_q <= {1'b0, shift_q[25:1]};
            ef_q    <= ef_q + 6'sd1;
          end else if (!shift_q[23]) begin
            shift_q <= {shift_q[24:0], 1'b0};
            ef_q    <= ef_q - 6'sd1;
          end
        end
        S_MUL: begin
          if (!mul_ph_q) begin
            prod_q   <= 48'({1'b1, scale_q[22:0]}) * 48'(shift_q[23:0]);
            mul_ph_q <= 1'b1;
          end else begin
            mul_ph_q <= 1'b0;
            // Product of two [1,2) values lies in [1,4); bit47 marks [2,4).
            if (prod_q[47]) begin
              mant_q   <= prod_q[46:24];
              exp_q    <= w_exp_base + 10'sd1;
`ifdef ROUND_NEAREST_EN
              guard_q  <= prod_q[23];
              sticky_q <= |prod_q[22:0];
`endif
            end else begin
              mant_q   <= prod_q[45:23];
              exp_q    <= w_exp_base;
`ifdef ROUND_NEAREST_EN
              guard_q  <= prod_q[22];
              sticky_q <= |prod_q[21:0];
`endif
            end
          end
        end
        S_PACK:  out_q <= w_pack;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fix2float32_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fix2float32_stage                                            |
// | Purpose  : Scoreboard bench for fix2float32_stage with directed vectors.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fix2float32_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [25:0] FIXED_IN = 26'd0;
  logic [31:0] FLOAT32_SCALE = 32'd0;
  logic [31:0] FLOAT32_OUT;
  logic        done;
  logic        ready;
  logic        overrun;

  typedef struct {
    string       name;
    logic [31:0] val;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  fix2float32_stage dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .FIXED_IN     (FIXED_IN),
    .FLOAT32_SCALE(FLOAT32_SCALE),
    .FLOAT32_OUT  (FLOAT32_OUT),
    .done         (done),
    .ready        (ready),
    .overrun      (overrun)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pops one expectation (value and edge of arrival).
  always @(negedge CLK) begin
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done at edge %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_value"}, FLOAT32_OUT, e.val);
        chk({e.name, "_edge"}, 32'(cyc), 32'(e.edge_n));
      end
    end
  end

  task automatic issue(input logic [25:0] f, input logic [31:0] s, output int edge_n);
    @(negedge CLK);
    FIXED_IN      = f;
    FLOAT32_SCALE = s;
    start         = 1'b1;
    @(posedge CLK);
    #1;
    start  = 1'b0;
    edge_n = cyc;
  endtask

  task automatic job(input string name, input logic [25:0] f, input logic [31:0] s,
                     input logic [31:0] exp, input int k, output int edge_n);
    exp_t e;
    issue(f, s, edge_n);
    e.name   = name;
    e.val    = exp;
    e.edge_n = edge_n + 4 + k;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CLK);
      #1;
      if (sb.size() == 0 && ready === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int n0;
    logic [31:0] rnd_exp;
`ifdef ROUND_NEAREST_EN
    rnd_exp = 32'h40100001;
`else
    rnd_exp = 32'h40100000;
`endif

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_out",     FLOAT32_OUT, 32'h0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_ready",   32'(ready),   32'd1);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // 1.0 * 1.0 with exact done/ready timing
    job("one_x_one", 26'h0800000, 32'h3F800000, 32'h3F800000, 0, e0);
    while (cyc < e0 + 4) @(negedge CLK);
    chk("t1_ready_in_done", 32'(ready), 32'd0);
    @(negedge CLK);
    chk("t1_ready_after", 32'(ready), 32'd1);

    job("two_x_two",   26'h1000000, 32'h40000000, 32'h40800000, 1, e0);  drain(40);
    job("left23",      26'h0000001, 32'h4B000000, 32'h3F800000, 23, e0); drain(60);
    job("tiny_normal", 26'h0000001, 32'h3F800000, 32'h34000000, 23, e0); drain(60);
    job("underflow",   26'h0000001, 32'h0B800000, 32'h00000000, 23, e0); drain(60);
    job("zero_in",     26'h0000000, 32'h42B20000, 32'h00000000, 0, e0);  drain(40);
    job("overflow",    26'h1000000, 32'h7F000000, 32'h7F800000, 1, e0);  drain(40);
    job("nan_pass",    26'h0800000, 32'h7FC00000, 32'h7FC00000, 0, e0);  drain(40);
    job("rounding",    26'h0C00001, 32'h3FC00000, rnd_exp, 0, e0);       drain(40);

    // Reset during NORM aborts the job silently
    n0 = done_cnt;
    issue(26'h0000001, 32'h4B000000, e0);
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_out",   FLOAT32_OUT, 32'h0);
    chk("abort_done",  32'(done), 32'd0);
    RST = 1'b0;
    repeat (35) @(negedge CLK);
    chk("abort_no_done", 32'(done_cnt - n0), 32'd0);

    // start while busy: overrun, single done, first result kept
    n0 = done_cnt;
    job("overrun_job", 26'h0800000, 32'h3FC00000, 32'h3FC00000, 0, e0);
    @(negedge CLK);
    @(negedge CLK);
    FIXED_IN      = 26'h0000000;
    FLOAT32_SCALE = 32'h42B20000;
    start         = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    @(negedge CLK);
    chk("overrun_set", 32'(overrun), 32'd1);
    drain(40);
    repeat (10) @(negedge CLK);
    chk("overrun_one_done", 32'(done_cnt - n0), 32'd1);
    chk("overrun_sticky",   32'(overrun), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // start together with RST is not captured
    n0 = done_cnt;
    @(negedge CLK);
    FIXED_IN      = 26'h0800000;
    FLOAT32_SCALE = 32'h3F800000;
    RST           = 1'b1;
    start         = 1'b1;
    @(negedge CLK);
    RST   = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_start_ready", 32'(ready), 32'd1);
    repeat (10) @(negedge CLK);
    chk("rst_start_no_done", 32'(done_cnt - n0), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
